// File: rtl/ioblock_cfg_ctrl.sv
// ioblock_cfg_ctrl
// Configuration controller for a bank of NUM_IO programmable I/O blocks.
// Each block holds three config bits {TSMUX[1], TSMUX[0], DORREG}. The host
// fills a local shadow array over a valid/ready write port. COMMIT serialises
// the whole shadow array onto the I/O config scan chain (highest block first,
// MSB first within a block), then strobes CFG_LATCH so every block updates at
// once.
//
// Ports:
//   IOCLK      sole clock, rising edge
//   RST        asynchronous active-high reset
//   WR_VALID   host write request
//   WR_READY   controller can accept a write (IDLE only)
//   WR_ADDR    target I/O block index
//   WR_DATA    {TSMUX[1], TSMUX[0], DORREG}
//   COMMIT     level-sampled request to shift the shadow array to the chain
//   BUSY       commit in progress (SHIFT and LATCH)
//   DONE       one-cycle pulse after a commit completes
//   ERR        sticky flag: write to an out-of-range address
//   CFG_SDO    serial config data to the chain
//   CFG_SEN    chain shift enable, high in the last cycle of each bit period
//   CFG_LATCH  one-cycle strobe: chain contents become the active config
module ioblock_cfg_ctrl #(
  parameter int NUM_IO    = 8,
  parameter int AW        = 3,
  parameter int SHIFT_DIV = 2
) (
  input  logic          IOCLK,
  input  logic          RST,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [2:0]    WR_DATA,
  input  logic          COMMIT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic          CFG_SDO,
  output logic          CFG_SEN,
  output logic          CFG_LATCH
);

  localparam int NBITS = 3 * NUM_IO;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] shadow;
  logic [BW-1:0]    bit_idx;
  logic [DW-1:0]    div_cnt;
  logic             done_q;
  logic             err_q;
  logic             wr_en;
  logic             addr_ok;
  logic             bit_end;

  assign wr_en   = (state == IDLE) && WR_VALID;
  assign addr_ok = ({1'b0, WR_ADDR} < (AW+1)'(NUM_IO));
  assign bit_end = (div_cnt == DIV_LAST);
  assign DONE    = done_q;
  assign ERR     = err_q;

  // Shadow block i lives at shadow[3*i+2 : 3*i], so counting bit_idx down
  // from the top delivers highest block first and TSMUX[1] first per block.
  always_comb begin
    state_nxt = state;
    WR_READY  = 1'b0;
    BUSY      = 1'b0;
    CFG_SDO   = 1'b0;
    CFG_SEN   = 1'b0;
    CFG_LATCH = 1'b0;
    case (state)
      IDLE: begin
        WR_READY = 1'b1;
        if (COMMIT) state_nxt = SHIFT;
      end
      SHIFT: begin
        BUSY    = 1'b1;
        CFG_SDO = shadow[bit_idx];
        CFG_SEN = bit_end;
        if (bit_end && (bit_idx == '0)) state_nxt = LATCH;
      end
      LATCH: begin
        BUSY      = 1'b1;
        CFG_LATCH = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shadow, flags and shift counters. Writes are only accepted in IDLE, so
  // the shadow is the commit-time snapshot for the whole shift.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      shadow  <= '0;
      bit_idx <= '0;
      div_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= (state == LATCH);

      if (wr_en && addr_ok) begin
        for (int i = 0; i < NUM_IO; i++) begin
          if (WR_ADDR == AW'(i)) shadow[3*i +: 3] <= WR_DATA;
        end
      end

      // Commit start wins over an out-of-range write on the same edge.
      if ((state == IDLE) && COMMIT) err_q <= 1'b0;
      else if (wr_en && !addr_ok)    err_q <= 1'b1;

      if (state == IDLE) begin
        bit_idx <= LAST_BIT;
        div_cnt <= '0;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule
